// File: rtl/vga_timing_gen.sv
`default_nettype none
//==============================================================================
// Module   : vga_timing_gen
// Desc     : VGA raster timing generator; geometry shadowed at frame boundaries.
// Revision : 1.0 - initial release
//==============================================================================
module vga_timing_gen #(
    parameter int CNT_WIDTH = 16,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 en_i,
    input  logic                 hpol_i,
    input  logic                 vpol_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [CNT_WIDTH-1:0] hvsize_i,
    input  logic [CNT_WIDTH-1:0] hfpsize_i,
    input  logic [CNT_WIDTH-1:0] hsnsize_i,
    input  logic [CNT_WIDTH-1:0] hbpsize_i,
    input  logic [CNT_WIDTH-1:0] vvsize_i,
    input  logic [CNT_WIDTH-1:0] vfpsize_i,
    input  logic [CNT_WIDTH-1:0] vsnsize_i,
    input  logic [CNT_WIDTH-1:0] vbpsize_i,
    output logic                 pix_tick_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 de_o,
    output logic [CNT_WIDTH-1:0] xpos_o,
    output logic [CNT_WIDTH-1:0] ypos_o,
    output logic                 frame_start_o,
    output logic                 line_end_o
);

    typedef enum logic [1:0] {
        PH_VIS = 2'd0,
        PH_FP  = 2'd1,
        PH_SN  = 2'd2,
        PH_BP  = 2'd3
    } phase_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    // Shadowed geometry, indexed by phase
    logic [CNT_WIDTH-1:0] hlen_q [4];
    logic [CNT_WIDTH-1:0] vlen_q [4];
    logic                 hpol_q, vpol_q;

    logic                 run_q, run_d, started_q, started_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    phase_t               hst_q, hst_d, vst_q, vst_d;
    logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic                 de_q, de_d, hact_q, hact_d, vact_q, vact_d;
    logic                 fs_q, fs_d, le_q, le_d;
    logic [CNT_WIDTH-1:0] xpos_q, xpos_d, ypos_q, ypos_d;

    logic w_tick, w_hlast, w_vlast, w_hwrap, w_vwrap, w_load, w_hpol, w_vpol;

    // A zero-length phase behaves as a one-tick phase
    function automatic logic phase_last(input logic [CNT_WIDTH-1:0] cnt,
                                        input logic [CNT_WIDTH-1:0] len);
        return (len == '0) || (cnt == len - CNT_ONE);
    endfunction

    function automatic phase_t phase_next(input phase_t ph);
        case (ph)
            PH_VIS:  return PH_FP;
            PH_FP:   return PH_SN;
            PH_SN:   return PH_BP;
            default: return PH_VIS;
        endcase
    endfunction

    assign w_tick  = en_i && run_q && (div_q >= div_i);
    assign w_hlast = phase_last(hcnt_q, hlen_q[hst_q]);
    assign w_vlast = phase_last(vcnt_q, vlen_q[vst_q]);
    assign w_hwrap = w_hlast && (hst_q == PH_BP);
    assign w_vwrap = w_vlast && (vst_q == PH_BP);
    assign w_load  = en_i && (!run_q || (w_tick && started_q && w_hwrap && w_vwrap));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < 4; i++) begin
                hlen_q[i] <= '0;
                vlen_q[i] <= '0;
            end
            hpol_q <= 1'b0;
            vpol_q <= 1'b0;
        end else if (w_load) begin
            hlen_q[PH_VIS] <= hvsize_i;
            hlen_q[PH_FP]  <= hfpsize_i;
            hlen_q[PH_SN]  <= hsnsize_i;
            hlen_q[PH_BP]  <= hbpsize_i;
            vlen_q[PH_VIS] <= vvsize_i;
            vlen_q[PH_FP]  <= vfpsize_i;
            vlen_q[PH_SN]  <= vsnsize_i;
            vlen_q[PH_BP]  <= vbpsize_i;
            hpol_q         <= hpol_i;
            vpol_q         <= vpol_i;
        end
    end

    always_comb begin
        run_d     = en_i;
        started_d = started_q;
        div_d     = div_q;
        hst_d     = hst_q;
        hcnt_d    = hcnt_q;
        vst_d     = vst_q;
        vcnt_d    = vcnt_q;
        fs_d      = 1'b0;
        le_d      = 1'b0;
        if (!en_i) begin
            started_d = 1'b0;
            div_d     = '0;
            hst_d     = PH_VIS;
            hcnt_d    = '0;
            vst_d     = PH_VIS;
            vcnt_d    = '0;
        end else if (run_q) begin
            div_d = w_tick ? '0 : div_q + DIV_ONE;
            if (w_tick && !started_q) begin
                // First tick after enable enters pixel (0,0); counters are already clear
                started_d = 1'b1;
                fs_d      = 1'b1;
            end else if (w_tick) begin
                if (w_hlast) begin
                    hst_d  = phase_next(hst_q);
                    hcnt_d = '0;
                    if (w_hwrap) begin
                        if (w_vlast) begin
                            vst_d  = phase_next(vst_q);
                            vcnt_d = '0;
                        end else begin
                            vcnt_d = vcnt_q + CNT_ONE;
                        end
                    end
                end else begin
                    hcnt_d = hcnt_q + CNT_ONE;
                end
                fs_d = w_hwrap && w_vwrap;
                le_d = (hst_d == PH_BP) && phase_last(hcnt_d, hlen_q[PH_BP]);
            end
        end
        de_d   = started_d && (hst_d == PH_VIS) && (vst_d == PH_VIS);
        hact_d = started_d && (hst_d == PH_SN);
        vact_d = started_d && (vst_d == PH_SN);
        xpos_d = (hst_d == PH_VIS) ? hcnt_d : '0;
        ypos_d = (vst_d == PH_VIS) ? vcnt_d : '0;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            run_q     <= 1'b0;
            started_q <= 1'b0;
            div_q     <= '0;
            hst_q     <= PH_VIS;
            hcnt_q    <= '0;
            vst_q     <= PH_VIS;
            vcnt_q    <= '0;
            de_q      <= 1'b0;
            hact_q    <= 1'b0;
            vact_q    <= 1'b0;
            fs_q      <= 1'b0;
            le_q      <= 1'b0;
            xpos_q    <= '0;
            ypos_q    <= '0;
        end else begin
            run_q     <= run_d;
            started_q <= started_d;
            div_q     <= div_d;
            hst_q     <= hst_d;
            hcnt_q    <= hcnt_d;
            vst_q     <= vst_d;
            vcnt_q    <= vcnt_d;
            de_q      <= de_d;
            hact_q    <= hact_d;
            vact_q    <= vact_d;
            fs_q      <= fs_d;
            le_q      <= le_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
        end
    end

    // While stopped the sync lines idle at the live polarity inputs
    assign w_hpol = run_q ? hpol_q : hpol_i;
    assign w_vpol = run_q ? vpol_q : vpol_i;

    assign pix_tick_o    = w_tick;
    assign hsync_o       = hact_q ? w_hpol : ~w_hpol;
    assign vsync_o       = vact_q ? w_vpol : ~w_vpol;
    assign de_o          = de_q;
    assign xpos_o        = xpos_q;
    assign ypos_o        = ypos_q;
    assign frame_start_o = fs_q;
    assign line_end_o    = le_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
//==============================================================================
// Module   : tb_vga_timing_gen
// Desc     : Scoreboard bench for vga_timing_gen.
// Revision : 1.0 - initial release
//==============================================================================
module tb_vga_timing_gen;
    localparam int CW = 16;
    localparam int DW = 8;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          en_i = 1'b0;
    logic          hpol_i = 1'b1;
    logic          vpol_i = 1'b1;
    logic [DW-1:0] div_i = '0;
    logic [CW-1:0] hvsize_i = 16'd4, hfpsize_i = 16'd1, hsnsize_i = 16'd2, hbpsize_i = 16'd1;
    logic [CW-1:0] vvsize_i = 16'd3, vfpsize_i = 16'd1, vsnsize_i = 16'd1, vbpsize_i = 16'd1;
    logic          pix_tick_o, hsync_o, vsync_o, de_o, frame_start_o, line_end_o;
    logic [CW-1:0] xpos_o, ypos_o;

    vga_timing_gen #(.CNT_WIDTH(CW), .DIV_WIDTH(DW)) dut (
        .pclk(pclk), .presetn(presetn), .en_i(en_i), .hpol_i(hpol_i), .vpol_i(vpol_i),
        .div_i(div_i), .hvsize_i(hvsize_i), .hfpsize_i(hfpsize_i), .hsnsize_i(hsnsize_i),
        .hbpsize_i(hbpsize_i), .vvsize_i(vvsize_i), .vfpsize_i(vfpsize_i),
        .vsnsize_i(vsnsize_i), .vbpsize_i(vbpsize_i), .pix_tick_o(pix_tick_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .xpos_o(xpos_o),
        .ypos_o(ypos_o), .frame_start_o(frame_start_o), .line_end_o(line_end_o)
    );

    always #5 pclk = ~pclk;

    int cyc_cnt = 0;
    always @(posedge pclk) cyc_cnt <= cyc_cnt + 1;

    string       tag_q[$];
    logic [31:0] val_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (val_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=queued_entry", obs);
            return;
        end
        t = tag_q.pop_front();
        e = val_q.pop_front();
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
        end
    endtask

    function automatic logic [5:0] obs_flags();
        return {pix_tick_o, frame_start_o, line_end_o, de_o, hsync_o, vsync_o};
    endfunction

    // Geometry 4/1/2/1 x 3/1/1/1, div 0, active-high sync; i = cycles since (0,0)
    function automatic logic [5:0] exp_flags(input int i);
        int h, v;
        h = i % 8;
        v = (i / 8) % 6;
        return {1'b1, i == 0, h == 7, (h < 4) && (v < 3), (h >= 5) && (h <= 6), v == 4};
    endfunction

    function automatic logic [31:0] exp_xy(input int i);
        int h, v;
        h = i % 8;
        v = (i / 8) % 6;
        return {CW'((h < 4) ? h : 0), CW'((v < 3) ? v : 0)};
    endfunction

    function automatic logic ev(input int code);
        case (code)
            0:       return frame_start_o;
            1:       return line_end_o;
            2:       return pix_tick_o;
            3:       return hsync_o == hpol_i;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_ev(input int code, output int stamp);
        int n;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!ev(code) && n < 300);
        if (!ev(code)) begin
            n_cmp++;
            n_bad++;
            $error("FAIL timeout_event%0d observed=%0d_cycles expected=event", code, n);
        end
        stamp = cyc_cnt;
    endtask

    task automatic raise_en(output int t0);
        en_i = 1'b0;
        repeat (3) @(negedge pclk);
        en_i = 1'b1;
        t0 = cyc_cnt;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, f, a, b, n;

        // Reset with enable high
        en_i = 1'b1;
        repeat (3) @(negedge pclk);
        push("rst_flags", 6'b000000); push("rst_xy", 32'd0);
        check(obs_flags());
        check({xpos_o, ypos_o});
        hpol_i = 1'b0; vpol_i = 1'b0;
        #1;
        push("rst_hsync_pol0", 1); push("rst_vsync_pol0", 1);
        check(hsync_o);
        check(vsync_o);
        hpol_i = 1'b1; vpol_i = 1'b1;
        en_i = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;

        // Baseline frame: full 48-cycle window
        raise_en(t0);
        push("fs_latency", 2);
        for (int i = 0; i < 48; i++) begin
            push("win_flags", exp_flags(i));
            push("win_xy", exp_xy(i));
        end
        push("frame_period", 48);
        wait_ev(0, f);
        check(f - t0);
        for (int i = 0; i < 48; i++) begin
            if (i > 0) @(negedge pclk);
            check(obs_flags());
            check({xpos_o, ypos_o});
        end
        wait_ev(0, a);
        check(a - f);

        // Divider 2
        div_i = 8'd2;
        raise_en(t0);
        push("div2_fs_latency", 4); push("div2_de_width", 12);
        push("div2_tick_period", 3); push("div2_line_period", 24);
        push("div2_ticks_per_line", 8);
        wait_ev(0, f);
        check(f - t0);
        n = 0;
        while (de_o && n < 100) begin
            n++;
            @(negedge pclk);
        end
        check(n);
        wait_ev(2, a); wait_ev(2, b);
        check(b - a);
        wait_ev(1, a); wait_ev(1, b);
        check(b - a);
        n = 0;
        repeat (24) begin
            @(negedge pclk);
            if (pix_tick_o) n++;
        end
        check(n);

        // Zero front porch, active-low hsync
        div_i = 8'd0; hfpsize_i = 16'd0; hpol_i = 1'b0;
        raise_en(t0);
        push("hfp0_hsync_offset", 5); push("hfp0_le_offset", 7); push("hfp0_line_period", 8);
        wait_ev(0, f);
        wait_ev(3, a);
        check(a - f);
        wait_ev(1, a);
        check(a - f);
        wait_ev(1, b);
        check(b - a);

        // hvsize change mid-frame takes effect at the next frame start
        push("mid_old_line0", 8); push("mid_old_line1", 8); push("mid_frame_period", 48);
        push("mid_new_de_width", 6); push("mid_new_line", 10);
        wait_ev(0, f);
        repeat (3) @(negedge pclk);
        hvsize_i = 16'd6;
        wait_ev(1, a); wait_ev(1, b);
        check(b - a);
        wait_ev(1, a);
        check(a - b);
        wait_ev(0, a);
        check(a - f);
        n = 0;
        while (de_o && n < 100) begin
            n++;
            @(negedge pclk);
        end
        check(n);
        wait_ev(1, a); wait_ev(1, b);
        check(b - a);

        // Enable drop at (2,1), then restart
        hvsize_i = 16'd4; hfpsize_i = 16'd1; hpol_i = 1'b1;
        raise_en(t0);
        push("drop_pos", {16'd2, 16'd1});
        push("drop_flags", 6'b000000); push("drop_xy", 32'd0);
        push("reraise_fs_latency", 2); push("reraise_xy", 32'd0); push("reraise_de", 1);
        wait_ev(0, f);
        repeat (10) @(negedge pclk);
        check({xpos_o, ypos_o});
        en_i = 1'b0;
        @(negedge pclk);
        check(obs_flags());
        check({xpos_o, ypos_o});
        en_i = 1'b1;
        t0 = cyc_cnt;
        wait_ev(0, f);
        check(f - t0);
        check({xpos_o, ypos_o});
        check(de_o);

        n_cmp++;
        assert (val_q.size() == 0) else begin
            n_bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", val_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
